// File: rtl/risc_spm_ctrl_g2_if.sv
// Controller <-> datapath/memory signal bundle; master is the control unit, slave is the datapath side.
// Every strobe and select is combinational from the controller; mem_ready stretches memory states.
interface risc_spm_ctrl_g2_if #(
    parameter int WORD_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 16
);
    localparam int SEL1_W = $clog2(NUM_REGS + 1);

    logic [WORD_W-1:0]   instruction;
    logic                zflag;
    logic                mem_ready;
    logic                resume;
    logic [NUM_REGS-1:0] load_reg;
    logic                load_pc;
    logic                inc_pc;
    logic                load_ir;
    logic                load_addr;
    logic                load_y;
    logic                load_z;
    logic                write;
    logic [SEL1_W-1:0]   sel_bus1;
    logic [1:0]          sel_bus2;
    logic                halted;
    logic                err;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  instruction, zflag, mem_ready, resume,
        output load_reg, load_pc, inc_pc, load_ir, load_addr, load_y, load_z, write,
               sel_bus1, sel_bus2, halted, err, instr_count
    );

    modport slave (
        output instruction, zflag, mem_ready, resume,
        input  load_reg, load_pc, inc_pc, load_ir, load_addr, load_y, load_z, write,
               sel_bus1, sel_bus2, halted, err, instr_count
    );
endinterface

// File: rtl/risc_spm_ctrl_g2.sv
// RISC_SPM multi-cycle control FSM: fetch/decode/execute/memory/branch, HALT with resume, sticky err, retire counter.
// Outputs are combinational from state and inputs; memory states hold while mem_ready is low.
module risc_spm_ctrl_g2 #(
    parameter int WORD_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    risc_spm_ctrl_g2_if.master  bus
);
    localparam int REG_W  = $clog2(NUM_REGS);
    localparam int SEL1_W = $clog2(NUM_REGS + 1);
    localparam logic [SEL1_W-1:0] SEL_PC = SEL1_W'(NUM_REGS);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2,
        S_WR1, S_WR2, S_BR1, S_HALT
    } state_t;

    state_t           state;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       opcode;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src;

    assign opcode = bus.instruction[WORD_W-1 -: 4];
    assign dst    = bus.instruction[2*REG_W-1:REG_W];
    assign src    = bus.instruction[REG_W-1:0];

    assign bus.err         = err_q;
    assign bus.instr_count = cnt_q;
    assign bus.halted      = (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FET1;
                S_FET1: state <= S_FET2;
                S_FET2: if (bus.mem_ready) state <= S_DEC;
                S_DEC: begin
                    // Every legal opcode except HALT retires on the way out of DEC.
                    if (opcode < OP_HALT) cnt_q <= cnt_q + CNT_W'(1);
                    case (opcode)
                        OP_NOP, OP_NOT:         state <= S_FET1;
                        OP_ADD, OP_SUB, OP_AND: state <= S_EX1;
                        OP_RD:                  state <= S_RD1;
                        OP_WR:                  state <= S_WR1;
                        OP_BR:                  state <= S_BR1;
                        OP_BRZ:                 state <= bus.zflag ? S_BR1 : S_FET1;
                        OP_HALT:                state <= S_HALT;
                        default: begin
                            err_q <= 1'b1;
                            state <= S_HALT;
                        end
                    endcase
                end
                S_EX1:  state <= S_FET1;
                S_RD1:  if (bus.mem_ready) state <= S_RD2;
                S_RD2:  if (bus.mem_ready) state <= S_FET1;
                S_WR1:  if (bus.mem_ready) state <= S_WR2;
                S_WR2:  if (bus.mem_ready) state <= S_FET1;
                S_BR1:  if (bus.mem_ready) state <= S_FET1;
                S_HALT: if (bus.resume) state <= S_FET1;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.load_reg  = '0;
        bus.load_pc   = 1'b0;
        bus.inc_pc    = 1'b0;
        bus.load_ir   = 1'b0;
        bus.load_addr = 1'b0;
        bus.load_y    = 1'b0;
        bus.load_z    = 1'b0;
        bus.write     = 1'b0;
        bus.sel_bus1  = '0;
        bus.sel_bus2  = 2'd0;
        case (state)
            S_FET1: begin
                bus.sel_bus1  = SEL_PC;
                bus.sel_bus2  = 2'd1;
                bus.load_addr = 1'b1;
            end
            S_FET2: begin
                bus.sel_bus2 = 2'd2;
                bus.load_ir  = bus.mem_ready;
                bus.inc_pc   = bus.mem_ready;
            end
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus.sel_bus1 = SEL1_W'(src);
                        bus.sel_bus2 = 2'd1;
                        bus.load_y   = 1'b1;
                    end
                    OP_NOT: begin
                        bus.sel_bus1 = SEL1_W'(src);
                        bus.load_reg = NUM_REGS'(1) << dst;
                        bus.load_z   = 1'b1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        bus.sel_bus1  = SEL_PC;
                        bus.sel_bus2  = 2'd1;
                        bus.load_addr = 1'b1;
                    end
                    OP_BRZ: begin
                        // Not taken: step the PC past the operand word.
                        if (bus.zflag) begin
                            bus.sel_bus1  = SEL_PC;
                            bus.sel_bus2  = 2'd1;
                            bus.load_addr = 1'b1;
                        end else begin
                            bus.inc_pc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EX1: begin
                bus.load_reg = NUM_REGS'(1) << dst;
                bus.load_z   = 1'b1;
            end
            S_RD1, S_WR1: begin
                bus.sel_bus2  = 2'd2;
                bus.load_addr = bus.mem_ready;
                bus.inc_pc    = bus.mem_ready;
            end
            S_RD2: begin
                bus.sel_bus2 = 2'd2;
                if (bus.mem_ready) bus.load_reg = NUM_REGS'(1) << dst;
            end
            S_WR2: begin
                // write is held through wait states until memory accepts it.
                bus.sel_bus1 = SEL1_W'(src);
                bus.write    = 1'b1;
            end
            S_BR1: begin
                bus.sel_bus2 = 2'd2;
                bus.load_pc  = bus.mem_ready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_risc_spm_ctrl_g2.sv
// Scoreboarded directed bench: stimulus queues the expected per-cycle controller outputs, a negedge monitor compares.
module tb_risc_spm_ctrl_g2;
    logic clk = 1'b0;
    logic rst;
    logic rst1;
    always #5 clk = ~clk;

    risc_spm_ctrl_g2_if #(.WORD_W(8),  .NUM_REGS(4), .CNT_W(16)) b0 ();
    risc_spm_ctrl_g2_if #(.WORD_W(10), .NUM_REGS(8), .CNT_W(2))  b1 ();

    risc_spm_ctrl_g2 #(.WORD_W(8),  .NUM_REGS(4), .CNT_W(16)) u0 (.clk(clk), .rst(rst),  .bus(b0.master));
    risc_spm_ctrl_g2 #(.WORD_W(10), .NUM_REGS(8), .CNT_W(2))  u1 (.clk(clk), .rst(rst1), .bus(b1.master));

    typedef struct packed {
        logic [7:0]  lreg;
        logic [6:0]  fl;   // {load_pc, inc_pc, load_ir, load_addr, load_y, load_z, write}
        logic [3:0]  s1;
        logic [1:0]  s2;
        logic        halted;
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    localparam logic [6:0] NO  = 7'h00;
    localparam logic [6:0] LPC = 7'h40;
    localparam logic [6:0] INC = 7'h20;
    localparam logic [6:0] LIR = 7'h10;
    localparam logic [6:0] LAD = 7'h08;
    localparam logic [6:0] LY  = 7'h04;
    localparam logic [6:0] LZ  = 7'h02;
    localparam logic [6:0] WR  = 7'h01;

    obs_t obs0, obs1;
    assign obs0 = {8'(b0.load_reg), b0.load_pc, b0.inc_pc, b0.load_ir, b0.load_addr, b0.load_y,
                   b0.load_z, b0.write, 4'(b0.sel_bus1), b0.sel_bus2, b0.halted, b0.err, 16'(b0.instr_count)};
    assign obs1 = {8'(b1.load_reg), b1.load_pc, b1.inc_pc, b1.load_ir, b1.load_addr, b1.load_y,
                   b1.load_z, b1.write, 4'(b1.sel_bus1), b1.sel_bus2, b1.halted, b1.err, 16'(b1.instr_count)};

    obs_t  exp_q[$];
    bit    dut_q[$];
    string nm_q[$];
    bit    cur;
    int    checks = 0;
    int    passed = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e, a;
            bit    d;
            string n;
            e = exp_q.pop_front();
            d = dut_q.pop_front();
            n = nm_q.pop_front();
            a = d ? obs1 : obs0;
            checks++;
            if (a === e) passed++;
            else $display("FAIL %s: got lreg=%h fl=%b s1=%0d s2=%0d halted=%b err=%b cnt=%0d, expected lreg=%h fl=%b s1=%0d s2=%0d halted=%b err=%b cnt=%0d",
                          n, a.lreg, a.fl, a.s1, a.s2, a.halted, a.err, a.cnt,
                          e.lreg, e.fl, e.s1, e.s2, e.halted, e.err, e.cnt);
        end
    end

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic chk(input string nm, input logic [7:0] lr, input logic [6:0] fl, input logic [3:0] s1,
                       input logic [1:0] s2, input logic h, input logic e, input logic [15:0] c);
        obs_t x;
        x = '{lreg: lr, fl: fl, s1: s1, s2: s2, halted: h, err: e, cnt: c};
        exp_q.push_back(x);
        dut_q.push_back(cur);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string p, input logic [3:0] pc, input logic e, input logic [15:0] c);
        chk({p, "_fet1"}, 8'h00, LAD, pc, 2'd1, 1'b0, e, c);
        chk({p, "_fet2"}, 8'h00, LIR | INC, 4'd0, 2'd2, 1'b0, e, c);
    endtask

    initial begin
        rst = 1'b0;
        rst1 = 1'b0;
        cur = 1'b0;
        b0.instruction = '0; b0.zflag = 1'b0; b0.mem_ready = 1'b0; b0.resume = 1'b0;
        b1.instruction = '0; b1.zflag = 1'b0; b1.mem_ready = 1'b0; b1.resume = 1'b0;
        @(posedge clk);
        #1;

        // Reset and first ADD R1,R2
        b0.instruction = 8'h16;
        b0.mem_ready = 1'b1;
        chk("reset_a", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        chk("reset_b", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        chk("idle", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        fetch("add", 4'd4, 1'b0, 16'd0);
        chk("add_dec", 8'h00, LY, 4'd2, 2'd1, 1'b0, 1'b0, 16'd0);
        chk("add_ex1", 8'h02, LZ, 4'd0, 2'd0, 1'b0, 1'b0, 16'd1);

        // RD R3 with two wait states in RD1
        b0.instruction = 8'h5C;
        fetch("rd", 4'd4, 1'b0, 16'd1);
        chk("rd_dec", 8'h00, LAD, 4'd4, 2'd1, 1'b0, 1'b0, 16'd1);
        b0.mem_ready = 1'b0;
        chk("rd1_wait_a", 8'h00, NO, 4'd0, 2'd2, 1'b0, 1'b0, 16'd2);
        chk("rd1_wait_b", 8'h00, NO, 4'd0, 2'd2, 1'b0, 1'b0, 16'd2);
        b0.mem_ready = 1'b1;
        chk("rd1", 8'h00, LAD | INC, 4'd0, 2'd2, 1'b0, 1'b0, 16'd2);
        chk("rd2", 8'h08, NO, 4'd0, 2'd2, 1'b0, 1'b0, 16'd2);

        // WR R0,R1 with a wait in FET2 and in WR2
        b0.instruction = 8'h61;
        chk("wr_fet1", 8'h00, LAD, 4'd4, 2'd1, 1'b0, 1'b0, 16'd2);
        b0.mem_ready = 1'b0;
        chk("wr_fet2_wait", 8'h00, NO, 4'd0, 2'd2, 1'b0, 1'b0, 16'd2);
        b0.mem_ready = 1'b1;
        chk("wr_fet2", 8'h00, LIR | INC, 4'd0, 2'd2, 1'b0, 1'b0, 16'd2);
        chk("wr_dec", 8'h00, LAD, 4'd4, 2'd1, 1'b0, 1'b0, 16'd2);
        chk("wr1", 8'h00, LAD | INC, 4'd0, 2'd2, 1'b0, 1'b0, 16'd3);
        b0.mem_ready = 1'b0;
        chk("wr2_wait", 8'h00, WR, 4'd1, 2'd0, 1'b0, 1'b0, 16'd3);
        b0.mem_ready = 1'b1;
        chk("wr2", 8'h00, WR, 4'd1, 2'd0, 1'b0, 1'b0, 16'd3);

        // BRZ not taken, then taken
        b0.instruction = 8'h80;
        b0.zflag = 1'b0;
        fetch("brz_nt", 4'd4, 1'b0, 16'd3);
        chk("brz_nt_dec", 8'h00, INC, 4'd0, 2'd0, 1'b0, 1'b0, 16'd3);
        b0.zflag = 1'b1;
        fetch("brz_t", 4'd4, 1'b0, 16'd4);
        chk("brz_t_dec", 8'h00, LAD, 4'd4, 2'd1, 1'b0, 1'b0, 16'd4);
        chk("br1", 8'h00, LPC, 4'd0, 2'd2, 1'b0, 1'b0, 16'd5);

        // Illegal opcode: sticky err, halt, resume
        b0.instruction = 8'hF0;
        b0.zflag = 1'b0;
        fetch("ill", 4'd4, 1'b0, 16'd5);
        chk("ill_dec", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd5);
        chk("ill_halt", 8'h00, NO, 4'd0, 2'd0, 1'b1, 1'b1, 16'd5);
        chk("ill_halt_hold", 8'h00, NO, 4'd0, 2'd0, 1'b1, 1'b1, 16'd5);
        b0.resume = 1'b1;
        chk("ill_halt_resume", 8'h00, NO, 4'd0, 2'd0, 1'b1, 1'b1, 16'd5);
        b0.resume = 1'b0;

        // HALT opcode does not retire; then reset mid-fetch clears err
        b0.instruction = 8'h90;
        fetch("halt", 4'd4, 1'b1, 16'd5);
        chk("halt_dec", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b1, 16'd5);
        b0.resume = 1'b1;
        chk("halt_state", 8'h00, NO, 4'd0, 2'd0, 1'b1, 1'b1, 16'd5);
        b0.resume = 1'b0;
        chk("resumed_fet1", 8'h00, LAD, 4'd4, 2'd1, 1'b0, 1'b1, 16'd5);
        rst = 1'b0;
        chk("rst_mid", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        chk("idle2", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        chk("post_rst_fet1", 8'h00, LAD, 4'd4, 2'd1, 1'b0, 1'b0, 16'd0);

        // Eight-register, 2-bit-counter instance: NOP wrap, then NOT R5,R6
        cur = 1'b1;
        b1.mem_ready = 1'b1;
        rst1 = 1'b1;
        chk("d1_idle", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            fetch("d1_nop", 4'd8, 1'b0, 16'(i % 4));
            chk("d1_nop_dec", 8'h00, NO, 4'd0, 2'd0, 1'b0, 1'b0, 16'(i % 4));
        end
        b1.instruction = 10'h12E;
        fetch("d1_not", 4'd8, 1'b0, 16'd1);
        chk("d1_not_dec", 8'h20, LZ, 4'd6, 2'd0, 1'b0, 1'b0, 16'd1);
        chk("d1_after_not", 8'h00, LAD, 4'd8, 2'd1, 1'b0, 1'b0, 16'd2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d undrained entries, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
